// File: rtl/peripheral_div.sv
// Memory-mapped multi-cycle unsigned restoring divider (one quotient bit per clock).
module peripheral_div #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_in,
  input  logic             cs,
  input  logic [4:0]       addr,
  input  logic             rd,
  input  logic             wr,
  output logic [31:0]      d_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [4:0] OFF_A      = 5'h00;
  localparam logic [4:0] OFF_B      = 5'h04;
  localparam logic [4:0] OFF_START  = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_Q      = 5'h10;
  localparam logic [4:0] OFF_R      = 5'h14;

  logic [0:0]       state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, q_reg, r_reg;
  logic [WIDTH-1:0] wa, wb, wrem;
  logic [CW-1:0]    cnt;
  logic             done, dz;

  logic             busy_c, write_c, start_c, last_c, ge_c;
  logic [WIDTH:0]   rem_sh_c, rem_nx_c;
  logic [WIDTH-1:0] wa_nx_c;
  logic [31:0]      rdata_c;

  // Bus decode; writes are only honoured while idle
  always_comb begin
    busy_c  = (state == S_BUSY);
    write_c = cs && wr && !busy_c;
    start_c = write_c && (addr == OFF_START) && d_in[0];
    last_c  = busy_c && (cnt == LAST);
  end

  // One restoring step: shift in dividend MSB, trial-subtract, quotient bit enters wa LSB
  always_comb begin
    rem_sh_c = {wrem, wa[WIDTH-1]};
    ge_c     = (rem_sh_c >= {1'b0, wb});
    rem_nx_c = ge_c ? (rem_sh_c - {1'b0, wb}) : rem_sh_c;
    wa_nx_c  = {wa[WIDTH-2:0], ge_c};
  end

  // Read mux
  always_comb begin
    rdata_c = '0;
    case (addr)
      OFF_STATUS: rdata_c = {29'b0, dz, done, busy_c};
      OFF_Q:      rdata_c = 32'(q_reg);
      OFF_R:      rdata_c = 32'(r_reg);
      default:    rdata_c = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_c) state_nx = S_BUSY;
      S_BUSY:  if (last_c)  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Operand registers, working registers, results and read data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_reg <= '0;
      b_reg <= '0;
      q_reg <= '0;
      r_reg <= '0;
      wa    <= '0;
      wb    <= '0;
      wrem  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      dz    <= 1'b0;
      d_out <= '0;
    end else begin
      if (write_c && addr == OFF_A) a_reg <= d_in;
      if (write_c && addr == OFF_B) b_reg <= d_in;
      if (start_c) begin
        wa   <= a_reg;
        wb   <= b_reg;
        wrem <= '0;
        cnt  <= '0;
        done <= 1'b0;
        dz   <= (b_reg == '0);
      end else if (busy_c) begin
        wa   <= wa_nx_c;
        wrem <= rem_nx_c[WIDTH-1:0];
        cnt  <= cnt + CW'(1);
        if (last_c) begin
          q_reg <= wa_nx_c;
          r_reg <= rem_nx_c[WIDTH-1:0];
          done  <= 1'b1;
        end
      end
      if (cs && rd) d_out <= rdata_c;
    end
  end

endmodule

// File: tb/tb_peripheral_div.sv
// Self-checking bench for peripheral_div with a behavioural divider model.
module tb_peripheral_div;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             resetn;
  logic [WIDTH-1:0] d_in;
  logic             cs;
  logic [4:0]       addr;
  logic             rd;
  logic             wr;
  logic [31:0]      d_out;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Model: operand registers, last accepted start edge, results
  int          ma, mb, m_start;
  logic [31:0] m_q_old, m_r_old, m_q_new, m_r_new;
  logic        m_dz;

  peripheral_div #(.WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn), .d_in(d_in), .cs(cs),
    .addr(addr), .rd(rd), .wr(wr), .d_out(d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index, readable #1 after each rising edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    ma = 0; mb = 0; m_start = -1;
    m_q_old = '0; m_r_old = '0; m_q_new = '0; m_r_new = '0; m_dz = 1'b0;
  endfunction

  function automatic logic model_busy(int e);
    return (m_start >= 0) && (e > m_start) && (e <= m_start + int'(WIDTH));
  endfunction

  function automatic logic [31:0] exp_q(int e);
    return (m_start >= 0 && e > m_start + int'(WIDTH)) ? m_q_new : m_q_old;
  endfunction

  function automatic logic [31:0] exp_r(int e);
    return (m_start >= 0 && e > m_start + int'(WIDTH)) ? m_r_new : m_r_old;
  endfunction

  function automatic logic [31:0] exp_status(int e);
    logic b, d, z;
    b = model_busy(e);
    d = (m_start >= 0) && (e > m_start + int'(WIDTH));
    z = (m_start >= 0) && (e > m_start) && m_dz;
    return {29'b0, z, d, b};
  endfunction

  task automatic bus_wr(input logic [4:0] a, input int data);
    int e;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = WIDTH'(data);
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
    e = cyc;
    if (!model_busy(e)) begin
      if (a == 5'h00) ma = data & 32'hFFFF;
      if (a == 5'h04) mb = data & 32'hFFFF;
      if (a == 5'h08 && data[0]) begin
        m_q_old = exp_q(e);
        m_r_old = exp_r(e);
        m_start = e;
        m_dz    = (mb == 0);
        if (mb == 0) begin
          m_q_new = 32'hFFFF;
          m_r_new = 32'(ma);
        end else begin
          m_q_new = 32'(ma / mb);
          m_r_new = 32'(ma % mb);
        end
      end
    end
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] v, output int e);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    v = d_out;
    e = cyc;
  endtask

  // Poll STATUS until not busy; every poll is compared against the model
  task automatic wait_done(output int nbusy);
    logic [31:0] v;
    int e;
    logic fin;
    nbusy = 0;
    fin = 1'b0;
    for (int i = 0; i < 4 * int'(WIDTH) && !fin; i++) begin
      bus_rd(5'h0C, v, e);
      total_cnt++;
      if (v !== exp_status(e)) $display("FAIL poll_status edge %0d: got %h expected %h", e, v, exp_status(e));
      else pass_cnt++;
      if (v[0] === 1'b1) nbusy++;
      else fin = 1'b1;
    end
    total_cnt++;
    if (!fin) $display("FAIL wait_done timeout: busy still %b expected 0", v[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int e;
    logic [4:0] offs [3];
    offs[0] = 5'h0C; offs[1] = 5'h10; offs[2] = 5'h14;
    total_cnt++;
    if (d_out !== 32'h0) $display("FAIL reset_dout: got %h expected 00000000", d_out);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      bus_rd(offs[i], v, e);
      total_cnt++;
      if (v !== 32'h0) $display("FAIL reset_read off %h: got %h expected 00000000", offs[i], v);
      else pass_cnt++;
    end
  endtask

  // Directed divide with hard expected values and exact-latency check
  task automatic test_directed(input int a, input int b, input logic [31:0] q, input logic [31:0] r,
                               input logic [31:0] st);
    logic [31:0] v;
    int e, nb;
    bus_wr(5'h00, a);
    bus_wr(5'h04, b);
    bus_wr(5'h08, 1);
    wait_done(nb);
    total_cnt++;
    if (nb !== int'(WIDTH)) $display("FAIL latency %0d/%0d: busy polls %0d expected %0d", a, b, nb, WIDTH);
    else pass_cnt++;
    bus_rd(5'h0C, v, e);
    total_cnt++;
    if (v !== st) $display("FAIL status %0d/%0d: got %h expected %h", a, b, v, st);
    else pass_cnt++;
    bus_rd(5'h10, v, e);
    total_cnt++;
    if (v !== q) $display("FAIL quotient %0d/%0d: got %h expected %h", a, b, v, q);
    else pass_cnt++;
    bus_rd(5'h14, v, e);
    total_cnt++;
    if (v !== r) $display("FAIL remainder %0d/%0d: got %h expected %h", a, b, v, r);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] v;
    int e, nb;
    bus_wr(5'h00, 1000);
    bus_wr(5'h04, 10);
    bus_wr(5'h08, 1);
    for (int i = 0; i < 4; i++) begin
      bus_rd(5'h10, v, e);
      total_cnt++;
      if (v !== exp_q(e)) $display("FAIL q_hold_busy: got %h expected %h", v, exp_q(e));
      else pass_cnt++;
    end
    bus_wr(5'h00, 7);
    bus_wr(5'h04, 1);
    bus_wr(5'h08, 1);
    wait_done(nb);
    bus_rd(5'h10, v, e);
    total_cnt++;
    if (v !== 32'd100) $display("FAIL ignore_q: got %h expected %h", v, 32'd100);
    else pass_cnt++;
    bus_rd(5'h14, v, e);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL ignore_r: got %h expected %h", v, 32'd0);
    else pass_cnt++;
    bus_wr(5'h08, 1);
    wait_done(nb);
    bus_rd(5'h10, v, e);
    total_cnt++;
    if (v !== 32'd100) $display("FAIL rerun_q: got %h expected %h", v, 32'd100);
    else pass_cnt++;
    bus_rd(5'h14, v, e);
    total_cnt++;
    if (v !== 32'd0) $display("FAIL rerun_r: got %h expected %h", v, 32'd0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int e;
    bus_wr(5'h00, 50000);
    bus_wr(5'h04, 3);
    bus_wr(5'h08, 1);
    for (int i = 0; i < 7; i++) bus_rd(5'h0C, v, e);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    bus_rd(5'h0C, v, e);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL abort_status: got %h expected 00000000", v);
    else pass_cnt++;
    bus_rd(5'h10, v, e);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL abort_q: got %h expected 00000000", v);
    else pass_cnt++;
    bus_rd(5'h14, v, e);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL abort_r: got %h expected 00000000", v);
    else pass_cnt++;
    test_directed(50000, 3, 32'd16666, 32'd2, 32'h2);
  endtask

  task automatic test_random();
    logic [31:0] v;
    int e, nb, a, b;
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, 65535));
      b = (i % 4 == 3) ? 0 : int'($urandom_range(1, (i % 2 == 0) ? 65535 : 300));
      bus_wr(5'h00, a);
      bus_wr(5'h04, b);
      bus_wr(5'h08, 1);
      wait_done(nb);
      bus_rd(5'h10, v, e);
      total_cnt++;
      if (v !== exp_q(e)) $display("FAIL rand_q %0d/%0d: got %h expected %h", a, b, v, exp_q(e));
      else pass_cnt++;
      bus_rd(5'h14, v, e);
      total_cnt++;
      if (v !== exp_r(e)) $display("FAIL rand_r %0d/%0d: got %h expected %h", a, b, v, exp_r(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_misc();
    logic [31:0] v, held;
    int e;
    bus_rd(5'h1C, v, e);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL unmapped_read: got %h expected 00000000", v);
    else pass_cnt++;
    bus_rd(5'h10, held, e);
    total_cnt++;
    if (held !== exp_q(e)) $display("FAIL misc_q: got %h expected %h", held, exp_q(e));
    else pass_cnt++;
    @(negedge clk);
    cs = 1'b1; rd = 1'b0; addr = 5'h0C;
    @(posedge clk); #1;
    cs = 1'b0;
    total_cnt++;
    if (d_out !== held) $display("FAIL dout_hold_no_rd: got %h expected %h", d_out, held);
    else pass_cnt++;
    @(negedge clk);
    cs = 1'b0; rd = 1'b1; addr = 5'h0C;
    @(posedge clk); #1;
    rd = 1'b0;
    total_cnt++;
    if (d_out !== held) $display("FAIL dout_hold_no_cs: got %h expected %h", d_out, held);
    else pass_cnt++;
  endtask

  initial begin
    resetn = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_directed(100, 7, 32'd14, 32'd2, 32'h2);
    test_directed(16'hFFFF, 1, 32'hFFFF, 32'd0, 32'h2);
    test_directed(5, 9, 32'd0, 32'd5, 32'h2);
    test_directed(1234, 0, 32'hFFFF, 32'd1234, 32'h6);
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_misc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
